reg_bank_shadow: RTL and testbench

Parametrised register bank with two copies of every register: a shadow copy and an active copy.
- Writes, with per-byte strobes, land in the shadow copy.
- A `commit` pulse copies the whole shadow bank into the active bank in one cycle; `abort` discards the staged writes.
- The active bank drives a flat parallel output and NUM_RD independent read ports with registered data.
- Sits between control/config logic and datapath blocks that need glitch-free multi-register updates.

---
 rtl/reg_bank_pkg.sv | 29 ++
 rtl/reg_bank_rd_port.sv | 38 +++
 rtl/reg_bank_shadow.sv | 115 +++++++++++
 tb/tb_reg_bank_shadow.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_bank_pkg.sv
// Shared helpers for the shadowed register bank: address width, packed-port
// offsets and byte-lane merging.
package reg_bank_pkg;

    // Widest register the lane-merge helper handles.
    localparam int MAX_W    = 256;
    localparam int MAX_STRB = MAX_W / 8;

    function automatic int addr_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic int port_lsb(input int port, input int w);
        return port * w;
    endfunction

    // Callers zero-extend into MAX_W and truncate the result to their width;
    // a partial top lane simply has its upper bits discarded.
    function automatic logic [MAX_W-1:0] strb_merge(input logic [MAX_W-1:0]    old_val,
                                                    input logic [MAX_W-1:0]    new_val,
                                                    input logic [MAX_STRB-1:0] strb);
        logic [MAX_W-1:0] res;
        for (int i = 0; i < MAX_W; i++) begin
            res[i] = strb[i / 8] ? new_val[i] : old_val[i];
        end
        return res;
    endfunction

endpackage

// File: rtl/reg_bank_rd_port.sv
// One registered read port onto the active register array.
module reg_bank_rd_port
    import reg_bank_pkg::*;
#(
    parameter int NUM_REGS = 16,
    parameter int WIDTH    = 8,
    parameter int AW       = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    input  logic [WIDTH-1:0] active [NUM_REGS],
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_valid
);

    localparam logic [AW:0] NREGS = (AW + 1)'(NUM_REGS);

    logic in_range;

    assign in_range = ({1'b0, rd_addr} < NREGS);

    // Read handshake: there is no ready; rd_en at edge N is always accepted and
    // answered by rd_valid during cycle N+1, with rd_data holding when idle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) begin
                rd_data <= in_range ? active[rd_addr] : '0;
            end
        end
    end

endmodule

// File: rtl/reg_bank_shadow.sv
// Shadowed register bank: byte-strobed writes stage into a shadow copy, and a
// commit publishes the whole bank to the active copy in one edge.
module reg_bank_shadow
    import reg_bank_pkg::*;
#(
    parameter int              NUM_REGS  = 16,
    parameter int              WIDTH     = 8,
    parameter int              NUM_RD    = 2,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    localparam int             AW        = addr_w(NUM_REGS),
    localparam int             STRB_W    = (WIDTH + 7) / 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      wr_en,
    input  logic [AW-1:0]             wr_addr,
    input  logic [WIDTH-1:0]          wr_data,
    input  logic [STRB_W-1:0]         wr_strb,
    input  logic                      commit,
    input  logic                      abort,
    input  logic [NUM_RD-1:0]         rd_en,
    input  logic [NUM_RD*AW-1:0]      rd_addr,
    output logic [NUM_RD*WIDTH-1:0]   rd_data,
    output logic [NUM_RD-1:0]         rd_valid,
    output logic [NUM_REGS*WIDTH-1:0] q,
    output logic                      pending,
    output logic                      wr_err
);

    localparam logic [AW:0] NREGS = (AW + 1)'(NUM_REGS);

    logic [WIDTH-1:0] shadow [NUM_REGS];
    logic [WIDTH-1:0] active [NUM_REGS];
    logic [WIDTH-1:0] staged [NUM_REGS];
    logic [WIDTH-1:0] wr_cur;
    logic [WIDTH-1:0] wr_merged;
    logic             wr_in_range;
    logic             wr_hit;
    logic             pending_r;
    logic             wr_err_r;

    assign wr_in_range = ({1'b0, wr_addr} < NREGS);
    assign wr_hit      = wr_en && wr_in_range && (wr_strb != '0);

    // staged is the shadow bank as it would look after this cycle's write.
    always_comb begin
        wr_cur = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            if (AW'(r) == wr_addr) begin
                wr_cur = shadow[r];
            end
        end
        wr_merged = WIDTH'(strb_merge(MAX_W'(wr_cur), MAX_W'(wr_data), MAX_STRB'(wr_strb)));
        for (int r = 0; r < NUM_REGS; r++) begin
            staged[r] = (wr_hit && (AW'(r) == wr_addr)) ? wr_merged : shadow[r];
        end
    end

    // Commit takes priority over abort when both are asserted.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                shadow[r] <= RESET_VAL;
                active[r] <= RESET_VAL;
            end
            pending_r <= 1'b0;
            wr_err_r  <= 1'b0;
        end else begin
            wr_err_r <= wr_en && !wr_in_range;
            if (commit) begin
                for (int r = 0; r < NUM_REGS; r++) begin
                    active[r] <= staged[r];
                    shadow[r] <= staged[r];
                end
                pending_r <= 1'b0;
            end else if (abort) begin
                for (int r = 0; r < NUM_REGS; r++) begin
                    shadow[r] <= active[r];
                end
                pending_r <= 1'b0;
            end else begin
                for (int r = 0; r < NUM_REGS; r++) begin
                    shadow[r] <= staged[r];
                end
                if (wr_hit) begin
                    pending_r <= 1'b1;
                end
            end
        end
    end

    assign pending = pending_r;
    assign wr_err  = wr_err_r;

    for (genvar r = 0; r < NUM_REGS; r++) begin : g_q
        assign q[r*WIDTH +: WIDTH] = active[r];
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        reg_bank_rd_port #(
            .NUM_REGS(NUM_REGS),
            .WIDTH   (WIDTH),
            .AW      (AW)
        ) u_rd_port (
            .clk     (clk),
            .rst_n   (rst_n),
            .rd_en   (rd_en[i]),
            .rd_addr (rd_addr[port_lsb(i, AW) +: AW]),
            .active  (active),
            .rd_data (rd_data[port_lsb(i, WIDTH) +: WIDTH]),
            .rd_valid(rd_valid[i])
        );
    end

endmodule

// File: tb/tb_reg_bank_shadow.sv
// Bench for reg_bank_shadow: directed scenarios on a 16x16 and a 12x12 bank
// plus a randomized run checked against a behavioural model of the 16x16 bank.
module tb_reg_bank_shadow;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    // 16 regs x 16 bits instance
    logic         a_wr_en, a_commit, a_abort, a_pending, a_wr_err;
    logic [3:0]   a_wr_addr;
    logic [15:0]  a_wr_data;
    logic [1:0]   a_wr_strb, a_rd_en, a_rd_valid;
    logic [7:0]   a_rd_addr;
    logic [31:0]  a_rd_data;
    logic [255:0] a_q;

    // 12 regs x 12 bits instance
    logic         b_wr_en, b_commit, b_abort, b_pending, b_wr_err;
    logic [3:0]   b_wr_addr;
    logic [11:0]  b_wr_data;
    logic [1:0]   b_wr_strb, b_rd_en, b_rd_valid;
    logic [7:0]   b_rd_addr;
    logic [23:0]  b_rd_data;
    logic [143:0] b_q;

    reg_bank_shadow #(.NUM_REGS(16), .WIDTH(16), .NUM_RD(2), .RESET_VAL(16'h0)) dut_a (
        .clk(clk), .rst_n(rst_n), .wr_en(a_wr_en), .wr_addr(a_wr_addr), .wr_data(a_wr_data),
        .wr_strb(a_wr_strb), .commit(a_commit), .abort(a_abort), .rd_en(a_rd_en),
        .rd_addr(a_rd_addr), .rd_data(a_rd_data), .rd_valid(a_rd_valid), .q(a_q),
        .pending(a_pending), .wr_err(a_wr_err)
    );

    reg_bank_shadow #(.NUM_REGS(12), .WIDTH(12), .NUM_RD(2), .RESET_VAL(12'h0)) dut_b (
        .clk(clk), .rst_n(rst_n), .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
        .wr_strb(b_wr_strb), .commit(b_commit), .abort(b_abort), .rd_en(b_rd_en),
        .rd_addr(b_rd_addr), .rd_data(b_rd_data), .rd_valid(b_rd_valid), .q(b_q),
        .pending(b_pending), .wr_err(b_wr_err)
    );

    // Behavioural model of the 16x16 bank
    logic [15:0] m_act [16];
    logic [15:0] m_shd [16];
    logic        m_pend;
    logic [31:0] m_rd_data;
    logic [1:0]  m_rd_valid;

    task automatic model_a();
        logic [15:0] stg [16];
        logic [15:0] mask;
        logic        eff;
        if (!rst_n) begin
            for (int r = 0; r < 16; r++) begin
                m_act[r] = 16'h0;
                m_shd[r] = 16'h0;
            end
            m_pend     = 1'b0;
            m_rd_data  = 32'h0;
            m_rd_valid = 2'b00;
            return;
        end
        for (int p = 0; p < 2; p++) begin
            m_rd_valid[p] = a_rd_en[p];
            if (a_rd_en[p]) m_rd_data[p*16 +: 16] = m_act[a_rd_addr[p*4 +: 4]];
        end
        stg  = m_shd;
        mask = {{8{a_wr_strb[1]}}, {8{a_wr_strb[0]}}};
        eff  = a_wr_en && (a_wr_strb != 2'b00);
        if (eff) stg[a_wr_addr] = (stg[a_wr_addr] & ~mask) | (a_wr_data & mask);
        if (a_commit) begin
            m_act  = stg;
            m_shd  = stg;
            m_pend = 1'b0;
        end else if (a_abort) begin
            m_shd  = m_act;
            m_pend = 1'b0;
        end else begin
            m_shd = stg;
            if (eff) m_pend = 1'b1;
        end
    endtask

    function automatic logic [255:0] exp_q_a();
        logic [255:0] v;
        for (int r = 0; r < 16; r++) v[r*16 +: 16] = m_act[r];
        return v;
    endfunction

    task automatic cycle_a(input logic rst, input logic we, input logic [3:0] wa,
                           input logic [15:0] wd, input logic [1:0] ws, input logic cm,
                           input logic ab, input logic [1:0] re, input logic [3:0] ra0,
                           input logic [3:0] ra1);
        rst_n     = rst;
        a_wr_en   = we;
        a_wr_addr = wa;
        a_wr_data = wd;
        a_wr_strb = ws;
        a_commit  = cm;
        a_abort   = ab;
        a_rd_en   = re;
        a_rd_addr = {ra1, ra0};
        @(posedge clk);
        model_a();
        #1;
    endtask

    task automatic cycle_b(input logic we, input logic [3:0] wa, input logic [11:0] wd,
                           input logic [1:0] ws, input logic cm, input logic [1:0] re,
                           input logic [3:0] ra0);
        b_wr_en   = we;
        b_wr_addr = wa;
        b_wr_data = wd;
        b_wr_strb = ws;
        b_commit  = cm;
        b_abort   = 1'b0;
        b_rd_en   = re;
        b_rd_addr = {4'd0, ra0};
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            cycle_a(1'b0, 1'($urandom), 4'($urandom), 16'($urandom), 2'($urandom),
                    1'($urandom), 1'($urandom), 2'($urandom), 4'($urandom), 4'($urandom));
        end
        n_checks++;
        if (a_q !== 256'h0) begin n_fail++; $display("FAIL reset_q got=%h exp=0", a_q); end
        n_checks++;
        if ({a_pending, a_wr_err, a_rd_valid} !== 4'b0000) begin
            n_fail++; $display("FAIL reset_flags got=%b exp=0000", {a_pending, a_wr_err, a_rd_valid});
        end
        n_checks++;
        if ({b_q, b_pending, b_wr_err, b_rd_valid} !== 148'h0) begin
            n_fail++; $display("FAIL reset_b got q=%h flags=%b exp=0", b_q, {b_pending, b_wr_err, b_rd_valid});
        end
        cycle_a(1'b1, 1'b1, 4'd1, 16'h9876, 2'b11, 1'b1, 1'b0, 2'b00, 4'd0, 4'd0);
        cycle_a(1'b1, 1'b1, 4'd2, 16'h4321, 2'b11, 1'b0, 1'b0, 2'b11, 4'd1, 4'd1);
        n_checks++;
        if (a_pending !== 1'b1 || a_q[31:16] !== 16'h9876) begin
            n_fail++; $display("FAIL pre_reset got pending=%b q1=%h exp 1 9876", a_pending, a_q[31:16]);
        end
        cycle_a(1'b0, 1'b1, 4'd3, 16'hFFFF, 2'b11, 1'b1, 1'b0, 2'b11, 4'd1, 4'd2);
        n_checks++;
        if (a_q !== 256'h0 || a_pending !== 1'b0 || a_rd_valid !== 2'b00 || a_rd_data !== 32'h0) begin
            n_fail++; $display("FAIL mid_reset got q=%h pending=%b rd_valid=%b rd_data=%h exp all 0",
                               a_q, a_pending, a_rd_valid, a_rd_data);
        end
    endtask

    task automatic test_write_commit();
        cycle_a(1'b1, 1'b1, 4'd3, 16'hABCD, 2'b11, 1'b0, 1'b0, 2'b00, 4'd0, 4'd0);
        n_checks++;
        if (a_pending !== 1'b1 || a_q[63:48] !== 16'h0000) begin
            n_fail++; $display("FAIL staged_write got pending=%b q3=%h exp 1 0000", a_pending, a_q[63:48]);
        end
        cycle_a(1'b1, 1'b0, 4'd0, 16'h0, 2'b00, 1'b0, 1'b0, 2'b01, 4'd3, 4'd0);
        n_checks++;
        if (a_rd_valid !== 2'b01 || a_rd_data[15:0] !== 16'h0000) begin
            n_fail++; $display("FAIL read_no_bypass got valid=%b data=%h exp 01 0000", a_rd_valid, a_rd_data[15:0]);
        end
        cycle_a(1'b1, 1'b0, 4'd0, 16'h0, 2'b00, 1'b1, 1'b0, 2'b10, 4'd0, 4'd3);
        n_checks++;
        if (a_q[63:48] !== 16'hABCD || a_pending !== 1'b0) begin
            n_fail++; $display("FAIL commit got q3=%h pending=%b exp ABCD 0", a_q[63:48], a_pending);
        end
        n_checks++;
        if (a_rd_valid !== 2'b10 || a_rd_data[31:16] !== 16'h0000) begin
            n_fail++; $display("FAIL read_at_commit got valid=%b data=%h exp 10 0000", a_rd_valid, a_rd_data[31:16]);
        end
        cycle_a(1'b1, 1'b0, 4'd0, 16'h0, 2'b00, 1'b0, 1'b0, 2'b01, 4'd3, 4'd0);
        n_checks++;
        if (a_rd_data[15:0] !== 16'hABCD) begin
            n_fail++; $display("FAIL read_after_commit got=%h exp=ABCD", a_rd_data[15:0]);
        end
    endtask

    task automatic test_partial_strobe();
        cycle_a(1'b1, 1'b1, 4'd3, 16'h1234, 2'b01, 1'b0, 1'b0, 2'b00, 4'd0, 4'd0);
        cycle_a(1'b1, 1'b0, 4'd0, 16'h0, 2'b00, 1'b1, 1'b0, 2'b00, 4'd0, 4'd0);
        n_checks++;
        if (a_q[63:48] !== 16'hAB34) begin
            n_fail++; $display("FAIL low_lane got q3=%h exp=AB34", a_q[63:48]);
        end
        cycle_a(1'b1, 1'b1, 4'd3, 16'hFFFF, 2'b00, 1'b0, 1'b0, 2'b00, 4'd0, 4'd0);
        n_checks++;
        if (a_pending !== 1'b0 || a_wr_err !== 1'b0 || a_q[63:48] !== 16'hAB34) begin
            n_fail++; $display("FAIL zero_strobe got pending=%b wr_err=%b q3=%h exp 0 0 AB34",
                               a_pending, a_wr_err, a_q[63:48]);
        end
    endtask

    task automatic test_abort_commit();
        cycle_a(1'b1, 1'b1, 4'd5, 16'h5555, 2'b11, 1'b0, 1'b0, 2'b00, 4'd0, 4'd0);
        cycle_a(1'b1, 1'b0, 4'd0, 16'h0, 2'b00, 1'b0, 1'b1, 2'b00, 4'd0, 4'd0);
        n_checks++;
        if (a_pending !== 1'b0) begin n_fail++; $display("FAIL abort_pending got=%b exp=0", a_pending); end
        cycle_a(1'b1, 1'b0, 4'd0, 16'h0, 2'b00, 1'b1, 1'b0, 2'b00, 4'd0, 4'd0);
        n_checks++;
        if (a_q[95:80] !== 16'h0000) begin n_fail++; $display("FAIL abort_discard got q5=%h exp=0000", a_q[95:80]); end
        cycle_a(1'b1, 1'b1, 4'd7, 16'h0F0F, 2'b11, 1'b1, 1'b0, 2'b00, 4'd0, 4'd0);
        n_checks++;
        if (a_q[127:112] !== 16'h0F0F || a_pending !== 1'b0) begin
            n_fail++; $display("FAIL write_with_commit got q7=%h pending=%b exp 0F0F 0", a_q[127:112], a_pending);
        end
        cycle_a(1'b1, 1'b1, 4'd9, 16'h0009, 2'b11, 1'b0, 1'b0, 2'b00, 4'd0, 4'd0);
        cycle_a(1'b1, 1'b0, 4'd0, 16'h0, 2'b00, 1'b1, 1'b1, 2'b00, 4'd0, 4'd0);
        n_checks++;
        if (a_q[159:144] !== 16'h0009 || a_pending !== 1'b0) begin
            n_fail++; $display("FAIL commit_beats_abort got q9=%h pending=%b exp 0009 0", a_q[159:144], a_pending);
        end
    endtask

    task automatic test_dual_read();
        cycle_a(1'b1, 1'b0, 4'd0, 16'h0, 2'b00, 1'b0, 1'b0, 2'b11, 4'd3, 4'd3);
        n_checks++;
        if (a_rd_valid !== 2'b11 || a_rd_data !== 32'hAB34_AB34) begin
            n_fail++; $display("FAIL dual_read got valid=%b data=%h exp 11 AB34AB34", a_rd_valid, a_rd_data);
        end
        cycle_a(1'b1, 1'b0, 4'd0, 16'h0, 2'b00, 1'b0, 1'b0, 2'b01, 4'd3, 4'd0);
        n_checks++;
        if (a_rd_valid !== 2'b01 || a_rd_data[31:16] !== 16'hAB34) begin
            n_fail++; $display("FAIL idle_hold got valid=%b data1=%h exp 01 AB34", a_rd_valid, a_rd_data[31:16]);
        end
    endtask

    task automatic test_small_bank();
        cycle_b(1'b1, 4'd0, 12'hA5A, 2'b11, 1'b0, 2'b00, 4'd0);
        cycle_b(1'b0, 4'd0, 12'h0, 2'b00, 1'b1, 2'b00, 4'd0);
        cycle_b(1'b0, 4'd0, 12'h0, 2'b00, 1'b0, 2'b01, 4'd0);
        n_checks++;
        if (b_rd_data[11:0] !== 12'hA5A) begin n_fail++; $display("FAIL b_read0 got=%h exp=A5A", b_rd_data[11:0]); end
        cycle_b(1'b0, 4'd0, 12'h0, 2'b00, 1'b0, 2'b01, 4'd14);
        n_checks++;
        if (b_rd_valid !== 2'b01 || b_rd_data[11:0] !== 12'h000) begin
            n_fail++; $display("FAIL b_read_oob got valid=%b data=%h exp 01 000", b_rd_valid, b_rd_data[11:0]);
        end
        cycle_b(1'b1, 4'd13, 12'hFFF, 2'b11, 1'b0, 2'b00, 4'd0);
        n_checks++;
        if (b_wr_err !== 1'b1 || b_pending !== 1'b0) begin
            n_fail++; $display("FAIL b_oob_write got wr_err=%b pending=%b exp 1 0", b_wr_err, b_pending);
        end
        cycle_b(1'b0, 4'd0, 12'h0, 2'b00, 1'b1, 2'b00, 4'd0);
        n_checks++;
        if (b_wr_err !== 1'b0 || b_q !== 144'hA5A) begin
            n_fail++; $display("FAIL b_oob_after got wr_err=%b q=%h exp 0 A5A", b_wr_err, b_q);
        end
        cycle_b(1'b1, 4'd2, 12'hFFF, 2'b10, 1'b0, 2'b00, 4'd0);
        cycle_b(1'b0, 4'd0, 12'h0, 2'b00, 1'b1, 2'b00, 4'd0);
        n_checks++;
        if (b_q[35:0] !== 36'hF00_000_A5A) begin
            n_fail++; $display("FAIL b_partial_lane got q[35:0]=%h exp F00000A5A", b_q[35:0]);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            cycle_a(($urandom_range(0, 63) != 0), 1'($urandom), 4'($urandom), 16'($urandom),
                    2'($urandom), ($urandom_range(0, 5) == 0), ($urandom_range(0, 7) == 0),
                    2'($urandom), 4'($urandom), 4'($urandom));
            n_checks++;
            if (a_q !== exp_q_a()) begin
                n_fail++; $display("FAIL rand_q cycle=%0d got=%h exp=%h", i, a_q, exp_q_a());
            end
            n_checks++;
            if (a_pending !== m_pend || a_wr_err !== 1'b0) begin
                n_fail++; $display("FAIL rand_flags cycle=%0d got pending=%b wr_err=%b exp %b 0",
                                   i, a_pending, a_wr_err, m_pend);
            end
            n_checks++;
            if (a_rd_valid !== m_rd_valid || a_rd_data !== m_rd_data) begin
                n_fail++; $display("FAIL rand_rd cycle=%0d got valid=%b data=%h exp %b %h",
                                   i, a_rd_valid, a_rd_data, m_rd_valid, m_rd_data);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        {a_wr_en, a_wr_addr, a_wr_data, a_wr_strb, a_commit, a_abort, a_rd_en, a_rd_addr} = '0;
        {b_wr_en, b_wr_addr, b_wr_data, b_wr_strb, b_commit, b_abort, b_rd_en, b_rd_addr} = '0;
        test_reset();
        test_write_commit();
        test_partial_strobe();
        test_abort_commit();
        test_dual_read();
        test_small_bank();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
